// File: rtl/dmem_be_slave.sv
// Data-memory responder: byte-lane stores, sign/zero-extended sub-word loads,
// one-cycle ready strobe after a programmable number of wait states.
module dmem_be_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W+1:0] addr,
    input  logic [3:0]        be,
    input  logic              u,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    logic              we_reg;
    logic [ADDR_W+1:0] addr_reg;
    logic [3:0]        be_reg;
    logic              u_reg;
    logic [31:0]       wdata_reg;
    logic              err_reg;
    logic [31:0]       rdata_hold_reg;

    logic              accept;
    logic [3:0]        src_be;
    logic [1:0]        src_lane;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       rd_word;
    logic [31:0]       wr_bytes;
    logic [3:0]        lane_we;
    logic [31:0]       load_data;
    logic [15:0]       sel_half;
    logic [7:0]        sel_byte;

    function automatic logic be_legal(input logic [3:0] b, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (b)
            4'b0001: ok = (lane == 2'd0);
            4'b0010: ok = (lane == 2'd1);
            4'b0100: ok = (lane == 2'd2);
            4'b1000: ok = (lane == 2'd3);
            4'b0011: ok = !lane[1];
            4'b1100: ok = lane[1];
            4'b1111: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign accept = (state_reg == S_IDLE) && req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            be_reg    <= 4'd0;
            u_reg     <= 1'b0;
            wdata_reg <= 32'd0;
        end else if (accept) begin
            we_reg    <= we;
            addr_reg  <= addr;
            be_reg    <= be;
            u_reg     <= u;
            wdata_reg <= wdata;
        end
    end

    // With zero wait states the response is entered straight from IDLE, so the
    // legality check and array read must look at the live inputs in that cycle.
    assign src_be   = (state_reg == S_IDLE) ? be : be_reg;
    assign src_lane = (state_reg == S_IDLE) ? addr[1:0] : addr_reg[1:0];
    assign rd_idx   = (state_reg == S_IDLE) ? addr[ADDR_W+1:2] : addr_reg[ADDR_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (state_next == S_RESP) begin
            err_reg <= !be_legal(src_be, src_lane);
        end
    end

    always_comb begin
        wr_bytes = {4{wdata_reg[7:0]}};
        if (be_reg == 4'b1111) begin
            wr_bytes = wdata_reg;
        end else if (be_reg == 4'b0011 || be_reg == 4'b1100) begin
            wr_bytes = {2{wdata_reg[15:0]}};
        end
    end

    // Writes commit on the edge that ends RESP; an async reset during RESP
    // drops the state first, so the write never happens.
    assign lane_we = (state_reg == S_RESP && we_reg && !err_reg) ? be_reg : 4'b0000;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk) begin
            if (lane_we[gi]) begin
                lane_mem[addr_reg[ADDR_W+1:2]] <= wr_bytes[gi*8 +: 8];
            end
            rd_byte_reg <= lane_mem[rd_idx];
        end

        assign rd_word[gi*8 +: 8] = rd_byte_reg;
    end

    always_comb begin
        load_data = 32'd0;
        sel_half  = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
        sel_byte  = rd_word[{addr_reg[1:0], 3'b000} +: 8];
        if (!we_reg && !err_reg) begin
            case (be_reg)
                4'b1111:          load_data = rd_word;
                4'b0011, 4'b1100: load_data = {{16{~u_reg & sel_half[15]}}, sel_half};
                default:          load_data = {{24{~u_reg & sel_byte[7]}}, sel_byte};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_hold_reg <= 32'd0;
        end else if (state_reg == S_RESP) begin
            rdata_hold_reg <= load_data;
        end
    end

    assign ready = (state_reg == S_RESP);
    assign rdata = ready ? load_data : rdata_hold_reg;
    assign err   = err_reg;

endmodule
